// File: rtl/knob_scanner_pkg.sv
// Shared constants, control index map and ADC addressing for the front-panel pot scanner.
package knob_pkg;

    localparam int unsigned NUM_KNOBS      = 12;
    localparam int unsigned KNOB_W         = 10;
    localparam int unsigned ADC_FRAME_BITS = 17;

    localparam logic [3:0] VOLUME           = 4'd0;
    localparam logic [3:0] PITCH            = 4'd1;
    localparam logic [3:0] DELAY_WET        = 4'd2;
    localparam logic [3:0] DELAY_RATE       = 4'd3;
    localparam logic [3:0] DELAY_FEEDBACK   = 4'd4;
    localparam logic [3:0] REVERB_WET       = 4'd5;
    localparam logic [3:0] REVERB_SIZE      = 4'd6;
    localparam logic [3:0] REVERB_FEEDBACK  = 4'd7;
    localparam logic [3:0] FILTER_QUALITY   = 4'd8;
    localparam logic [3:0] FILTER_CUTOFF    = 4'd9;
    localparam logic [3:0] DISTORTION_DRIVE = 4'd10;
    localparam logic [3:0] CRUSH_PRESSURE   = 4'd11;

    typedef struct packed {
        logic       adc_sel;
        logic [2:0] channel;
    } adc_addr_t;

    // Indices 0-7 sit on ADC0 channels 0-7, indices 8-11 on ADC1 channels 0-3.
    function automatic adc_addr_t knob_addr(input logic [3:0] idx);
        adc_addr_t a;
        a.adc_sel = (idx >= 4'd8);
        a.channel = idx[2:0];
        return a;
    endfunction

endpackage

// File: rtl/knob_scanner_if.sv
// SPI pin bundle between the pot scanner and the two front-panel ADCs.
interface knob_scanner_if;
    logic cipo;
    logic copi;
    logic dclk;
    logic cs0;
    logic cs1;

    modport master (input cipo, output copi, output dclk, output cs0, output cs1);
    modport slave  (output cipo, input copi, input dclk, input cs0, input cs1);
endinterface

// File: rtl/knob_scanner_spi_adc_frame.sv
// One MCP3008-style single-ended conversion frame (SPI mode 0,0): CS setup, 17 dclk
// periods, CS hold. A pending start at the end of the hold chains straight into the next frame.
module spi_adc_frame
    import knob_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  adc_addr_t         addr,
    output logic              busy,
    output logic              done,
    output logic [KNOB_W-1:0] result,
    knob_scanner_if.master    spi
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CS_SETUP = 2'd1;
    localparam logic [1:0] SHIFT    = 2'd2;
    localparam logic [1:0] CS_HOLD  = 2'd3;

    localparam int unsigned      DIV_W        = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] HALF_END     = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] FULL_END     = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [4:0]       LAST_BIT     = 5'(ADC_FRAME_BITS - 1);
    localparam logic [4:0]       SAMPLE_FIRST = 5'(ADC_FRAME_BITS - KNOB_W);

    logic [1:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_cnt;
    logic [3:0]        cmd;
    logic [KNOB_W-1:0] shreg;
    logic              copi, dclk, cs0, cs1;
    logic              launch;

    assign launch = start && ((state == IDLE) || ((state == CS_HOLD) && (div_cnt == FULL_END)));
    assign busy   = (state != IDLE);
    assign result = shreg;

    assign spi.copi = copi;
    assign spi.dclk = dclk;
    assign spi.cs0  = cs0;
    assign spi.cs1  = cs1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            cmd     <= '0;
            shreg   <= '0;
            copi    <= 1'b0;
            dclk    <= 1'b0;
            cs0     <= 1'b1;
            cs1     <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                CS_SETUP: begin
                    if (div_cnt == HALF_END) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // cipo is captured on the same edge that raises dclk
                    if (div_cnt == HALF_END) begin
                        dclk <= 1'b1;
                        if (bit_cnt >= SAMPLE_FIRST)
                            shreg <= {shreg[KNOB_W-2:0], spi.cipo};
                    end
                    if (div_cnt == FULL_END) begin
                        div_cnt <= '0;
                        dclk    <= 1'b0;
                        copi    <= cmd[3];
                        cmd     <= {cmd[2:0], 1'b0};
                        if (bit_cnt == LAST_BIT) begin
                            state <= CS_HOLD;
                            cs0   <= 1'b1;
                            cs1   <= 1'b1;
                            copi  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (div_cnt == FULL_END) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            // Start bit goes out immediately; the remaining command bits follow on falling edges.
            if (launch) begin
                state   <= CS_SETUP;
                div_cnt <= '0;
                cmd     <= {1'b1, addr.channel};
                copi    <= 1'b1;
                cs0     <= addr.adc_sel;
                cs1     <= ~addr.adc_sel;
            end
        end
    end

endmodule

// File: rtl/knob_scanner.sv
// Round-robin scanner for the 12 front-panel potentiometers over two SPI ADCs.
// Optional build macro KNOB_HYST_EN: suppress updates that move a value by less than 2 LSB.
module knob_scanner
    import knob_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               scan_en,
    knob_scanner_if.master                     spi,
    output logic [NUM_KNOBS-1:0][KNOB_W-1:0]   knobs,
    output logic                               knob_valid,
    output logic [3:0]                         knob_idx,
    output logic                               scan_done
);

    if (CLK_DIV < 2) begin : g_div_check
        $error("knob_scanner: CLK_DIV must be at least 2");
    end

    logic [1:0]        rst_sync;
    logic              rst_n_i;
    logic [3:0]        idx;
    adc_addr_t         addr;
    logic              busy;
    logic              done;
    logic [KNOB_W-1:0] result;
    logic              upd;

    // Assert passes straight through; release is delayed two clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= '0;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    assign addr = knob_addr(idx);

`ifdef KNOB_HYST_EN
    logic signed [KNOB_W:0] diff;
    assign diff = $signed({1'b0, result}) - $signed({1'b0, knobs[idx]});
    assign upd  = (diff >= 11'sd2) || (diff <= -11'sd2);
`else
    assign upd = 1'b1;
`endif

    spi_adc_frame #(.CLK_DIV(CLK_DIV)) u_frame (
        .clk    (clk),
        .rst_n  (rst_n_i),
        .start  (scan_en),
        .addr   (addr),
        .busy   (busy),
        .done   (done),
        .result (result),
        .spi    (spi)
    );

    // idx advances during the hold so the chained frame picks up the next channel's address.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx        <= '0;
            knobs      <= '0;
            knob_valid <= 1'b0;
            knob_idx   <= '0;
            scan_done  <= 1'b0;
        end else begin
            knob_valid <= 1'b0;
            scan_done  <= 1'b0;
            if (!busy) begin
                idx <= '0;
            end else if (done) begin
                if (upd) begin
                    knobs[idx] <= result;
                    knob_valid <= 1'b1;
                end
                knob_idx  <= idx;
                scan_done <= (idx == 4'(NUM_KNOBS - 1));
                idx       <= (idx == 4'(NUM_KNOBS - 1)) ? '0 : idx + 4'd1;
            end
        end
    end

endmodule
